// File: rtl/wrap_counter_bank.sv
// wrap_counter_bank
//   Bank of N independent bounded counters. Each channel counts inside
//   [LO, HI] with its own enable, direction and synchronous load. At a range
//   end a channel wraps to the opposite end (MODE 0) or stays at that end
//   (MODE 1). Either way it raises a one-cycle edge_hit pulse.
//
// Parameters
//   W     counter width in bits
//   N     number of channels
//   LO    lowest legal count and reset value
//   HI    highest legal count (0 <= LO < HI <= 2^W-1)
//   MODE  0 = wrap at range ends, 1 = saturate at range ends
//
// Ports
//   clk       clock, all state updates on posedge
//   rst       synchronous active-high reset
//   en        [N]    per-channel count enable
//   dir       [N]    per-channel direction, 1 = up, 0 = down
//   ld        [N]    per-channel synchronous load request
//   ld_val    [N*W]  per-channel load values, channel i at [i*W +: W]
//   count     [N*W]  per-channel registered counts
//   edge_hit  [N]    one-cycle pulse when a boundary event takes effect
//   ld_err    [N]    sticky, set when an out-of-range load is rejected
//
// Optional build macro
//   WRAP_COUNTER_PROP_EN  compiles range and edge_hit assertions plus an
//                         edge_hit cover. Behaviour is unchanged either way.

module wrap_counter_bank #(
  parameter int W    = 4,
  parameter int N    = 2,
  parameter int LO   = 1,
  parameter int HI   = 15,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   en,
  input  logic [N-1:0]   dir,
  input  logic [N-1:0]   ld,
  input  logic [N*W-1:0] ld_val,
  output logic [N*W-1:0] count,
  output logic [N-1:0]   edge_hit,
  output logic [N-1:0]   ld_err
);

  if (LO < 0 || LO >= HI || longint'(HI) > ((longint'(1) << W) - 1)) begin : g_bad_range
    $error("wrap_counter_bank: requires 0 <= LO < HI <= 2^W-1");
  end

  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("wrap_counter_bank: MODE must be 0 or 1");
  end

  localparam logic [W-1:0] LO_W = W'(LO);
  localparam logic [W-1:0] HI_W = W'(HI);
  // Range checks are done one bit wider so they stay meaningful when HI
  // is the all-ones value.
  localparam logic [W:0]   LO_X = (W+1)'(LO);
  localparam logic [W:0]   HI_X = (W+1)'(HI);

  function automatic logic in_range(input logic [W-1:0] v);
    return ({1'b0, v} >= LO_X) && ({1'b0, v} <= HI_X);
  endfunction

  // True when a step in the requested direction would leave the range.
  function automatic logic at_bound(input logic [W-1:0] c, input logic up);
    return up ? (c == HI_W) : (c == LO_W);
  endfunction

  // Next count for an enabled step. The boundary compare decides the wrap
  // or saturate case, so the +/-1 never relies on natural overflow.
  function automatic logic [W-1:0] step(input logic [W-1:0] c, input logic up);
    logic [W-1:0] nxt;
    if (at_bound(c, up)) begin
      if (MODE == 1) nxt = c;
      else           nxt = up ? LO_W : HI_W;
    end else begin
      nxt = up ? (c + W'(1)) : (c - W'(1));
    end
    return nxt;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0] cnt_p0;
    logic         hit_p0;
    logic         err_p0;
    logic [W-1:0] ldv;

    assign ldv = ld_val[i*W +: W];

    // ---- stage p0: count / pulse / sticky error registers ----
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_p0 <= LO_W;
        hit_p0 <= 1'b0;
        err_p0 <= 1'b0;
      end else if (ld[i]) begin
        // A rejected load still consumes the cycle: en is dropped.
        hit_p0 <= 1'b0;
        if (in_range(ldv)) cnt_p0 <= ldv;
        else               err_p0 <= 1'b1;
      end else if (en[i]) begin
        cnt_p0 <= step(cnt_p0, dir[i]);
        hit_p0 <= at_bound(cnt_p0, dir[i]);
      end else begin
        hit_p0 <= 1'b0;
      end
    end

    assign count[i*W +: W] = cnt_p0;
    assign edge_hit[i]     = hit_p0;
    assign ld_err[i]       = err_p0;

`ifdef WRAP_COUNTER_PROP_EN
    logic rst_seen;
    always_ff @(posedge clk) begin
      if (rst) rst_seen <= 1'b1;
    end

    always @(posedge clk) begin
      if (rst_seen) begin
        assert (in_range(cnt_p0));
        assert (!hit_p0 || cnt_p0 == LO_W || cnt_p0 == HI_W);
      end
    end

    cover property (@(posedge clk) hit_p0);
`endif
  end

endmodule

// File: tb/tb_wrap_counter_bank.sv
// tb_wrap_counter_bank
//   Directed bench for wrap_counter_bank. u0 is the default wrap build
//   (W=4, N=2, LO=1, HI=15, MODE 0). u1 is a saturating build
//   (LO=3, HI=9, MODE 1). Expected values are hand-computed constants.

module tb_wrap_counter_bank;

  logic       clk = 1'b0;
  logic       rst;

  logic [1:0] en0, dir0, ld0, hit0, err0;
  logic [7:0] ldv0, cnt0;
  logic [1:0] en1, dir1, ld1, hit1, err1;
  logic [7:0] ldv1, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wrap_counter_bank #(.W(4), .N(2), .LO(1), .HI(15), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .en(en0), .dir(dir0), .ld(ld0), .ld_val(ldv0),
    .count(cnt0), .edge_hit(hit0), .ld_err(err0)
  );

  wrap_counter_bank #(.W(4), .N(2), .LO(3), .HI(9), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .dir(dir1), .ld(ld1), .ld_val(ldv1),
    .count(cnt1), .edge_hit(hit1), .ld_err(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en0 = '0; dir0 = '0; ld0 = '0; ldv0 = '0;
    en1 = '0; dir1 = '0; ld1 = '0; ldv1 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_u0_cnt", 32'(cnt0), 32'h11);
    check_eq("rst_u0_hit", 32'(hit0), 0);
    check_eq("rst_u0_err", 32'(err0), 0);
    check_eq("rst_u1_cnt", 32'(cnt1), 32'h33);

    // u0 ch0 counts up through 2..15 and wraps to 1
    en0 = 2'b01; dir0 = 2'b01;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_eq($sformatf("up_cnt%0d", k), 32'(cnt0[3:0]), (k == 15) ? 1 : 1 + k);
      check_eq($sformatf("up_hit%0d", k), 32'(hit0[0]), (k == 15) ? 1 : 0);
    end
    check_eq("up_ch1_idle", 32'(cnt0[7:4]), 1);

    // u0 ch1 counts down from LO, wraps to HI; ch0 held
    en0 = 2'b10; dir0 = 2'b00;
    tick();
    check_eq("dn_cnt_a", 32'(cnt0[7:4]), 15);
    check_eq("dn_hit_a", 32'(hit0[1]), 1);
    tick();
    check_eq("dn_cnt_b", 32'(cnt0[7:4]), 14);
    check_eq("dn_hit_b", 32'(hit0[1]), 0);
    tick();
    check_eq("dn_cnt_c", 32'(cnt0[7:4]), 13);
    check_eq("dn_ch0_hold", 32'(cnt0[3:0]), 1);
    idle();
    tick();
    check_eq("hold_hit", 32'(hit0), 0);

    // u1 ch0 saturating: load 9, up stays at 9 with edge_hit each cycle
    ld1 = 2'b01; ldv1 = 8'h09;
    tick();
    check_eq("sat_ld9", 32'(cnt1[3:0]), 9);
    check_eq("sat_ld9_hit", 32'(hit1[0]), 0);
    ld1 = 2'b00; en1 = 2'b01; dir1 = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("sat_hi_cnt%0d", k), 32'(cnt1[3:0]), 9);
      check_eq($sformatf("sat_hi_hit%0d", k), 32'(hit1[0]), 1);
    end
    dir1 = 2'b00;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq($sformatf("sat_dn_cnt%0d", k), 32'(cnt1[3:0]), (k == 6) ? 3 : 8 - k);
      check_eq($sformatf("sat_dn_hit%0d", k), 32'(hit1[0]), (k == 6) ? 1 : 0);
    end

    // u1 ch1: simultaneous ld and en -> ld wins; out-of-range loads rejected
    en1 = 2'b10; dir1 = 2'b10; ld1 = 2'b10; ldv1 = 8'h50;
    tick();
    check_eq("ldwin_cnt", 32'(cnt1[7:4]), 5);
    ldv1 = 8'hA0;
    tick();
    check_eq("rej_hi_cnt", 32'(cnt1[7:4]), 5);
    check_eq("rej_hi_err", 32'(err1), 32'b10);
    ldv1 = 8'h20;
    tick();
    check_eq("rej_lo_cnt", 32'(cnt1[7:4]), 5);
    idle();

    // u0 ch0 rejected load of 0 with en high: count held, sticky error
    ld0 = 2'b01; ldv0 = 8'h00; en0 = 2'b01; dir0 = 2'b01;
    tick();
    check_eq("rej0_cnt", 32'(cnt0[3:0]), 1);
    check_eq("rej0_err", 32'(err0), 32'b01);
    check_eq("rej0_hit", 32'(hit0[0]), 0);
    idle();
    tick();
    check_eq("err_sticky", 32'(err0[0]), 1);
    ld0 = 2'b01; ldv0 = 8'h05;
    tick();
    check_eq("ld5_cnt", 32'(cnt0[3:0]), 5);
    check_eq("ld5_err", 32'(err0[0]), 1);
    ldv0 = 8'h0F;
    tick();
    check_eq("ld15_cnt", 32'(cnt0[3:0]), 15);
    ld0 = 2'b00; en0 = 2'b01; dir0 = 2'b01;
    tick();
    check_eq("wrap_max_cnt", 32'(cnt0[3:0]), 1);
    check_eq("wrap_max_hit", 32'(hit0[0]), 1);

    // Reset beats ld and en and clears the pending pulse and sticky error
    rst = 1'b1; ld0 = 2'b01; ldv0 = 8'h07; en0 = 2'b01; dir0 = 2'b01;
    tick();
    rst = 1'b0;
    idle();
    check_eq("rst_mid_cnt", 32'(cnt0), 32'h11);
    check_eq("rst_mid_hit", 32'(hit0), 0);
    check_eq("rst_mid_err", 32'(err0), 0);
    check_eq("rst_mid_u1err", 32'(err1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
